lr35902_timer: RTL

Memory-mapped timer peripheral for 0xff04-0xff07 (DIV, TIMA, TMA, TAC). It responds to the timer chip select produced by the high-page I/O decoder and exposes byte read/write access. A free-running system counter drives DIV and a selectable TIMA tick. TIMA overflow triggers a TMA reload and a one-cycle interrupt request, which feeds the IF register.

---
 rtl/lr35902_timer_if.sv | 23 ++
 rtl/lr35902_timer.sv | 118 +++++++++++
 2 files changed

// File: rtl/lr35902_timer_if.sv
// Byte-wide register bus between the high-page I/O decoder / CPU and the
// timer peripheral, plus the timer interrupt request back to the IF register.
interface lr35902_timer_if;
    logic       cs;
    logic [1:0] adr;
    logic [7:0] din;
    logic       write;
    logic       read;
    logic [7:0] dout;
    logic       irq;

    // CPU / decoder side
    modport master (
        output cs, adr, din, write, read,
        input  dout, irq
    );

    // Timer side
    modport slave (
        input  cs, adr, din, write, read,
        output dout, irq
    );
endinterface

// File: rtl/lr35902_timer.sv
// LR35902 timer block: DIV/TIMA/TMA/TAC at 0xff04-0xff07.
// A free-running 16-bit system counter feeds DIV and, through TAC, the
// falling-edge detector that clocks TIMA. TIMA overflow schedules a delayed
// TMA reload that coincides with a one-clock interrupt pulse.
module lr35902_timer #(
    // Clocks from the overflow edge to the TMA reload edge (1..8)
    parameter int RELOAD_DELAY = 4
) (
    input  logic              clk,
    input  logic              reset,
    lr35902_timer_if.slave    bus
);

    localparam logic [3:0] RELOAD_INIT = 4'(RELOAD_DELAY);
    // sys_cnt bit used as tick source for each TAC[1:0] selection
    localparam int TAP_BIT [4] = '{9, 3, 5, 7};

    logic [15:0] sys_cnt_reg;
    logic [7:0]  tima_reg, tima_next;
    logic [7:0]  tma_reg;
    logic [2:0]  tac_reg;
    logic [3:0]  reload_cnt_reg, reload_cnt_next;
    logic        irq_reg, irq_next;
    logic        tick_prev_reg;

    logic [3:0]  tap;
    logic        tick_in;
    logic        tick_fall;
    logic        wr_div, wr_tima, wr_tma, wr_tac;

    // Decoded, chip-select-qualified write strobes
    assign wr_div  = bus.cs & bus.write & (bus.adr == 2'd0);
    assign wr_tima = bus.cs & bus.write & (bus.adr == 2'd1);
    assign wr_tma  = bus.cs & bus.write & (bus.adr == 2'd2);
    assign wr_tac  = bus.cs & bus.write & (bus.adr == 2'd3);

    // Candidate tick taps off the system counter
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tap
            assign tap[gi] = sys_cnt_reg[TAP_BIT[gi]];
        end
    endgenerate

    // Gated tick and its registered falling-edge detect; DIV/TAC writes can
    // create a falling edge here and that increment is deliberate.
    assign tick_in   = tac_reg[2] & tap[tac_reg[1:0]];
    assign tick_fall = tick_prev_reg & ~tick_in;

    // System counter: free-running, cleared by any DIV write
    always_ff @(posedge clk) begin
        if (!reset)
            sys_cnt_reg <= 16'h0000;
        else if (wr_div)
            sys_cnt_reg <= 16'h0000;
        else
            sys_cnt_reg <= sys_cnt_reg + 16'h0001;
    end

    // TIMA / reload / irq next state; reload edge has top priority, then CPU
    // write (which also cancels a pending reload), then the tick.
    always_comb begin
        tima_next       = tima_reg;
        reload_cnt_next = (reload_cnt_reg != 4'd0) ? reload_cnt_reg - 4'd1 : 4'd0;
        irq_next        = 1'b0;
        if (reload_cnt_reg == 4'd1) begin
            // A TMA write in the reload cycle is forwarded straight into TIMA
            tima_next = wr_tma ? bus.din : tma_reg;
            irq_next  = 1'b1;
        end else if (wr_tima) begin
            tima_next       = bus.din;
            reload_cnt_next = 4'd0;
        end else if (tick_fall) begin
            if (tima_reg == 8'hff) begin
                tima_next       = 8'h00;
                reload_cnt_next = RELOAD_INIT;
            end else begin
                tima_next = tima_reg + 8'h01;
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            tima_reg       <= 8'h00;
            tma_reg        <= 8'h00;
            tac_reg        <= 3'b000;
            reload_cnt_reg <= 4'd0;
            irq_reg        <= 1'b0;
            tick_prev_reg  <= 1'b0;
        end else begin
            tima_reg       <= tima_next;
            reload_cnt_reg <= reload_cnt_next;
            irq_reg        <= irq_next;
            tick_prev_reg  <= tick_in;
            if (wr_tma)
                tma_reg <= bus.din;
            if (wr_tac)
                tac_reg <= bus.din[2:0];
        end
    end

    // Combinational read mux; idle bus reads as 0xff
    always_comb begin
        bus.dout = 8'hff;
        if (bus.cs && bus.read) begin
            case (bus.adr)
                2'd0:    bus.dout = sys_cnt_reg[15:8];
                2'd1:    bus.dout = tima_reg;
                2'd2:    bus.dout = tma_reg;
                default: bus.dout = {5'b11111, tac_reg};
            endcase
        end
    end

    assign bus.irq = irq_reg;

endmodule
